// File: rtl/bj_pkg.sv
// Shared blackjack constants: button indices (lower index wins arbitration),
// channel counts, bet width and the bet weighting helper.
package bj_pkg;

  localparam int BTN_NEW_GAME = 0;
  localparam int BTN_NEXT     = 1;
  localparam int BTN_STAND    = 2;
  localparam int BTN_HIT      = 3;
  localparam int BTN_DOUBLE   = 4;

  localparam int NUM_BTN = 5;
  localparam int NUM_SW  = 5;
  localparam int BET_W   = 4;

  // Switch channel layout: split first, then bet bits LSB upward.
  localparam int SW_SPLIT   = 0;
  localparam int SW_BET_LSB = 1;

  // Weighted bet total: bit i is worth 2**i chips.
  function automatic logic [BET_W-1:0] bet_total(
    input logic [BET_W-1:0] b
  );
    int t;
    t = 0;
    for (int i = 0; i < BET_W; i++) begin
      if (b[i]) t = t + (1 << i);
    end
    return BET_W'(t);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: SYNC_STAGES-deep synchroniser then a stability counter.
// Ports: clk, reset (async high), raw (pin), level (debounced output).
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SS-1:0] sync_q;
  logic          s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SS-2:0], raw};
    end
  end

  assign s = sync_q[SS-1];

  // Any sample that agrees with the current level restarts the count,
  // so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      level <= s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bj_input_conditioner.sv
// Debounces buttons/switches, turns presses into single arbitrated command
// pulses, and registers the bet total. Ports: raw pins in; command pulses,
// split/bet levels, bet_value and dropped out.
module bj_input_conditioner
  import bj_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_new_game_raw,
  input  logic             btn_next_raw,
  input  logic             btn_hit_raw,
  input  logic             btn_stand_raw,
  input  logic             btn_double_raw,
  input  logic             sw_split_raw,
  input  logic [BET_W-1:0] sw_bet_raw,
  output logic             new_game,
  output logic             next,
  output logic             hit,
  output logic             stand,
  output logic             double,
  output logic             split,
  output logic [BET_W-1:0] bet,
  output logic [BET_W-1:0] bet_value,
  output logic             dropped
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_prev;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] cmd_q;
  logic [NUM_SW-1:0]  sw_raw;
  logic [NUM_SW-1:0]  sw_lvl;
  logic               dropped_q;
  logic [BET_W-1:0]   bet_value_q;

  assign btn_raw[BTN_NEW_GAME] = btn_new_game_raw;
  assign btn_raw[BTN_NEXT]     = btn_next_raw;
  assign btn_raw[BTN_STAND]    = btn_stand_raw;
  assign btn_raw[BTN_HIT]      = btn_hit_raw;
  assign btn_raw[BTN_DOUBLE]   = btn_double_raw;

  assign sw_raw = {sw_bet_raw, sw_split_raw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .level (btn_lvl[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_raw[i]),
      .level (sw_lvl[i])
    );
  end

  assign rise = btn_lvl & ~btn_prev;

  // Isolate the lowest set bit: index 0 carries the highest priority.
  assign grant = rise & (~rise + NUM_BTN'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev    <= '0;
      cmd_q       <= '0;
      dropped_q   <= 1'b0;
      bet_value_q <= '0;
    end else begin
      btn_prev    <= btn_lvl;
      cmd_q       <= grant;
      dropped_q   <= |(rise & ~grant);
      bet_value_q <= bet_total(sw_lvl[SW_BET_LSB +: BET_W]);
    end
  end

  assign new_game  = cmd_q[BTN_NEW_GAME];
  assign next      = cmd_q[BTN_NEXT];
  assign stand     = cmd_q[BTN_STAND];
  assign hit       = cmd_q[BTN_HIT];
  assign double    = cmd_q[BTN_DOUBLE];
  assign dropped   = dropped_q;
  assign split     = sw_lvl[SW_SPLIT];
  assign bet       = sw_lvl[SW_BET_LSB +: BET_W];
  assign bet_value = bet_value_q;

endmodule

// File: doc/bj_input_conditioner.md
Name: bj_input_conditioner

Overview:
- Sits directly upstream of the blackjack game top and the segment display wrapper, between the Basys 3 pins and the game logic.
- Synchronises, debounces and edge-detects the five push buttons, and converts each press into a single-cycle command pulse.
- Synchronises and debounces the split and bet switches into stable levels, and computes the bet value.
- Arbitrates simultaneous presses so the game FSM receives at most one command per cycle.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required before a debounced level changes (10 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high system reset
- btn_new_game_raw  in  1  raw new-game button (game restart, distinct from reset)
- btn_next_raw  in  1  raw next button
- btn_hit_raw  in  1  raw hit button
- btn_stand_raw  in  1  raw stand button
- btn_double_raw  in  1  raw double button
- sw_split_raw  in  1  raw split switch
- sw_bet_raw  in  4  raw bet switches {bet_8, bet_4, bet_2, bet_1}
- new_game  out  1  one-cycle command pulse
- next  out  1  one-cycle command pulse
- hit  out  1  one-cycle command pulse
- stand  out  1  one-cycle command pulse
- double  out  1  one-cycle command pulse
- split  out  1  debounced split level
- bet  out  4  debounced bet switch levels
- bet_value  out  4  registered bet total, 8*bet[3]+4*bet[2]+2*bet[1]+bet[0], range 0..15
- dropped  out  1  one-cycle pulse when arbitration discarded at least one press

Behaviour:
- Reset (async assert, synchronous deassert handled externally) clears all synchroniser flops, debounce counters, stable levels and edge registers, and drives every output to 0.
- Per channel (10 channels: 5 buttons, split, 4 bet bits):
  - The SYNC_STAGES flop chain produces s.
  - The stable level d and the counter cnt (width $clog2(DEBOUNCE_CYCLES)) update as follows.
  - If s == d: cnt <= 0.
  - If s != d and cnt == DEBOUNCE_CYCLES-1: d <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any bounce shorter than DEBOUNCE_CYCLES samples returns cnt to 0, and d is unchanged.
- Button edge: a rise is flagged when d is 1 and d_prev is 0. A rise produces a request for exactly one cycle. Releases and held buttons produce nothing, so there is no auto-repeat.
- Arbitration, with requests in the same cycle:
  - Fixed priority is new_game > next > stand > hit > double.
  - Only the winner's pulse is asserted, registered one cycle after the request.
  - Losers are discarded, not queued.
  - dropped pulses in the same cycle as the winner.
- Latency: a raw transition is first sampled at edge k. The corresponding command pulse is high for the single cycle following edge k + SYNC_STAGES + DEBOUNCE_CYCLES. A switch level change appears on split/bet at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1. bet_value follows one cycle later.
- A button held through reset deassertion debounces to 1 after the normal latency and produces one pulse, which is intended.
- Reset asserted mid-count aborts the count immediately and no pulse is produced. The first post-reset evaluation starts from d = 0.
- At most one of new_game/next/hit/stand/double is high in any cycle (invariant).

Decomposition:
- Shared package bj_pkg:
  - button index constants BTN_NEW_GAME=0, BTN_NEXT=1, BTN_STAND=2, BTN_HIT=3, BTN_DOUBLE=4, with lower index meaning higher priority;
  - NUM_BTN=5, NUM_SW=5;
  - the bet width constant BET_W=4, shared with the game top and the display.
- Sub-module debounce_channel: parameters DEBOUNCE_CYCLES and SYNC_STAGES; ports clk, reset, raw, level.
  - Instantiate it 10 times via generate.
  - Edge detection, arbitration and bet_value stay in bj_input_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean hit press: btn_hit_raw goes 0->1, first sampled at edge 10, held for 20 cycles -> hit high for exactly the cycle after edge 16, no other outputs, dropped=0. Release -> no pulse.
- Bounce rejection: btn_next_raw toggles 1,0,1,0 on successive cycles, then stays 0 -> next never pulses. A second trial with a 3-cycle high glitch -> no pulse.
- Simultaneous press: btn_stand_raw and btn_double_raw rise on the same edge and are held -> stand pulses once, double never pulses, dropped pulses in the same cycle.
- Bet switches: sw_bet_raw changes 0000->1011 -> bet=1011 at edge k+5 and bet_value=11 one cycle later. A 2-cycle glitch to 1111 leaves bet_value=11.
- Reset mid-debounce: btn_new_game_raw rises, and reset is asserted 3 cycles later for 2 cycles -> all outputs 0 during reset, no pulse within the aborted window. The button is still held after reset -> new_game pulses once, SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after reset deassertion.
- Held button: btn_hit_raw held high for 100 cycles -> exactly one hit pulse. A press after release -> a second pulse.
